crossbar_arbiter: RTL

CROSSBAR_ARBITER -- requirements
Module: crossbar_arbiter

---
 rtl/crossbar_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/crossbar_arbiter.sv
// Per-slave round-robin ownership arbiter for an M x S crossbar. An optional hold limit
// revokes an owner once other masters have waited MAXHOLD cycles for the same slave.
module crossbar_arbiter #(
    parameter int M       = 3,
    parameter int S       = 2,
    parameter int MAXHOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [M-1:0]           m_req,
    input  logic [$clog2(S)*M-1:0] m_req_sid,
    output logic [M-1:0]           m_gnt,
    output logic [$clog2(M)*S-1:0] m_sel_array,
    output logic [$clog2(S)*M-1:0] s_sel_array,
    output logic [S-1:0]           s_owned
);
    localparam int MW    = $clog2(M);
    localparam int SW    = $clog2(S);
    localparam int CNT_W = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t           r_state [S];
    logic [MW-1:0]    r_owner [S];
    logic [MW-1:0]    r_ptr   [S];
    logic [CNT_W-1:0] r_cnt   [S];

    state_t           w_state_nxt [S];
    logic [MW-1:0]    w_owner_nxt [S];
    logic [MW-1:0]    w_ptr_nxt   [S];
    logic [CNT_W-1:0] w_cnt_nxt   [S];

    logic [M-1:0]     w_owns;
    logic [M-1:0]     w_cand [S];

    logic [M-1:0]     w_gnt_nxt;
    logic [MW*S-1:0]  w_msel_nxt;
    logic [SW*M-1:0]  w_ssel_nxt;
    logic [S-1:0]     w_owned_nxt;

    // A master already holding any slave is never a candidate, which keeps it to one slave.
    always_comb begin
        w_owns = '0;
        for (int j = 0; j < S; j++) begin
            for (int i = 0; i < M; i++) begin
                if (r_state[j] == OWNED && r_owner[j] == MW'(i)) w_owns[i] = 1'b1;
            end
        end
        for (int j = 0; j < S; j++) begin
            w_cand[j] = '0;
            for (int i = 0; i < M; i++) begin
                w_cand[j][i] = m_req[i] && !w_owns[i] && (m_req_sid[i*SW +: SW] == SW'(j));
            end
        end
    end

    always_comb begin : next_state
        logic [MW-1:0] win;
        logic          found;
        logic          own_req;
        logic          own_hit;
        logic          contended;
        for (int j = 0; j < S; j++) begin
            w_state_nxt[j] = r_state[j];
            w_owner_nxt[j] = r_owner[j];
            w_ptr_nxt[j]   = r_ptr[j];
            w_cnt_nxt[j]   = r_cnt[j];
            win            = '0;
            found          = 1'b0;
            own_req        = 1'b0;
            own_hit        = 1'b0;
            contended      = |w_cand[j];
            case (r_state[j])
                IDLE: begin
                    w_cnt_nxt[j] = '0;
                    // Lowest candidate overall, then overridden by lowest candidate at or above ptr.
                    for (int i = M - 1; i >= 0; i--) begin
                        if (w_cand[j][i]) begin
                            win   = MW'(i);
                            found = 1'b1;
                        end
                    end
                    for (int i = M - 1; i >= 0; i--) begin
                        if (w_cand[j][i] && MW'(i) >= r_ptr[j]) win = MW'(i);
                    end
                    if (found) begin
                        w_state_nxt[j] = OWNED;
                        w_owner_nxt[j] = win;
                        w_ptr_nxt[j]   = (win == MW'(M - 1)) ? '0 : win + MW'(1);
                    end
                end
                OWNED: begin
                    for (int i = 0; i < M; i++) begin
                        if (r_owner[j] == MW'(i)) begin
                            own_req = m_req[i];
                            own_hit = (m_req_sid[i*SW +: SW] == SW'(j));
                        end
                    end
                    if (!own_req || !own_hit) begin
                        w_state_nxt[j] = IDLE;
                        w_cnt_nxt[j]   = '0;
                    end else if (MAXHOLD > 0 && contended) begin
                        if (r_cnt[j] == CNT_W'(MAXHOLD)) begin
                            w_state_nxt[j] = IDLE;
                            w_cnt_nxt[j]   = '0;
                        end else begin
                            w_cnt_nxt[j] = r_cnt[j] + CNT_W'(1);
                        end
                    end
                end
                default: w_state_nxt[j] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < S; j++) begin
            if (rst) begin
                r_state[j] <= IDLE;
                r_ptr[j]   <= '0;
                r_cnt[j]   <= '0;
            end else begin
                r_state[j] <= w_state_nxt[j];
                r_ptr[j]   <= w_ptr_nxt[j];
                r_cnt[j]   <= w_cnt_nxt[j];
            end
            r_owner[j] <= w_owner_nxt[j];
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSMs.
    always_comb begin
        w_gnt_nxt   = '0;
        w_msel_nxt  = '0;
        w_ssel_nxt  = '0;
        w_owned_nxt = '0;
        for (int j = 0; j < S; j++) begin
            if (w_state_nxt[j] == OWNED) begin
                w_owned_nxt[j]          = 1'b1;
                w_msel_nxt[j*MW +: MW]  = w_owner_nxt[j];
                for (int i = 0; i < M; i++) begin
                    if (w_owner_nxt[j] == MW'(i)) begin
                        w_gnt_nxt[i]           = 1'b1;
                        w_ssel_nxt[i*SW +: SW] = SW'(j);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_gnt       <= '0;
            m_sel_array <= '0;
            s_sel_array <= '0;
            s_owned     <= '0;
        end else begin
            m_gnt       <= w_gnt_nxt;
            m_sel_array <= w_msel_nxt;
            s_sel_array <= w_ssel_nxt;
            s_owned     <= w_owned_nxt;
        end
    end

endmodule
